// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the N:1 registered multiplexer and its round-robin
// arbiter.
//   MODE_FIXED / MODE_RR : encodings of the `mode` input
//   MAX_CH               : largest supported channel count
//   rr_last_init()       : reset value of the round-robin `last` pointer
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH = 16;

  // `last` resets to the highest channel so that the first search starts at
  // channel 0.
  function automatic int rr_last_init(input int n_ch);
    return n_ch - 1;
  endfunction

endpackage

// File: rtl/mux_nto1_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin channel picker. Searches last+1, last+2, ...
// (modulo N_CH), ending at `last`; the first requesting channel wins.
//   req         in  N_CH  per-channel request (the channel valids)
//   last        in  SW    most recently granted channel
//   grant       out SW    winning channel index (equals `last` when idle)
//   grant_valid out 1     at least one channel requested
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   last,
  output logic [SW-1:0]   grant,
  output logic            grant_valid
);

  int idx;

  always_comb begin
    grant       = last;
    grant_valid = 1'b0;
    idx         = 0;
    // k runs 1..N_CH so `last` itself is visited last, giving it the lowest
    // priority; a lone requester is still granted every cycle.
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last) + k) % N_CH;
      if (!grant_valid && req[idx[SW-1:0]]) begin
        grant       = SW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// mux_nto1_reg
// N-channel to 1 multiplexer with per-channel valid/ready and a registered
// output stage. Fixed-select mode uses `sel`; round-robin mode cycles fairly
// over the valid channels.
//
// Build option: MUX_RR_EN
//   defined   : round-robin arbiter and `last` pointer present, `mode` selects
//   undefined : `mode` is ignored and the mux always uses fixed select
//
// Ports
//   clk        in  1       rising-edge clock
//   rst_n      in  1       asynchronous active-low reset
//   mode       in  1       0 = fixed select, 1 = round-robin
//   sel        in  SW      channel used in fixed mode
//   in_data    in  N_CH*W  channel i at [i*W +: W]
//   in_valid   in  N_CH    per-channel valid
//   in_ready   out N_CH    per-channel ready (one-hot or zero)
//   out_data   out W       registered data
//   out_ch     out SW      channel that supplied out_data
//   out_valid  out 1       output register holds data
//   out_ready  in  1       consumer accepts data
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// on the same side. Input side: only the granted channel sees ready, and only
// while the output register is empty or being drained this cycle. Output
// side: out_data/out_ch stay stable while out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          fix_valid;
  logic          load;
  logic [W-1:0]  grant_data;

  // Fixed select: an out-of-range sel (non power-of-two N_CH) never grants.
  always_comb begin
    fix_valid = 1'b0;
    if (int'(sel) < N_CH) begin
      fix_valid = in_valid[sel];
    end
  end

`ifdef MUX_RR_EN
  logic [SW-1:0] last;
  logic [SW-1:0] rr_grant;
  logic          rr_valid;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req         (in_valid),
    .last        (last),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = fix_valid;
    end
  end

  // Advances only on an accepted round-robin transfer, so a stalled output
  // keeps the pointer where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SW'(rr_last_init(N_CH));
    end else if (load && (mode == MODE_RR)) begin
      last <= grant;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign grant       = sel;
  assign grant_valid = fix_valid;
`endif

  // rst_n in the term keeps in_ready low while reset is held.
  assign load = rst_n && (!out_valid || out_ready) && grant_valid;

  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign grant_data = in_data[int'(grant)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
module tb_mux_nto1_reg;
  import mux_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int SW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              mode;
  logic [SW-1:0]     sel;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  mux_nto1_reg #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- scoreboard ----------------
  logic [SW+W-1:0] exp_q[$];
  logic [SW+W-1:0] mon_item;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel i carries k*16+i in vector k, so every word is traceable.
  function automatic logic [N_CH*W-1:0] make_data(input int k);
    logic [N_CH*W-1:0] d;
    for (int i = 0; i < N_CH; i++) d[i*W +: W] = W'(k*16 + i);
    return d;
  endfunction

  function automatic logic [SW+W-1:0] exp_word(input int k, input int ch);
    return {SW'(ch), W'(k*16 + ch)};
  endfunction

  // Monitor: a word leaves the DUT whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_unexpected: got ch=%0d data=%0h, expected no output", out_ch, out_data);
      end else begin
        mon_item = exp_q.pop_front();
        check("mon_ch", 64'(out_ch), 64'(mon_item[SW+W-1:W]));
        check("mon_data", 64'(out_data), 64'(mon_item[W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic m, input logic [SW-1:0] s, input logic [N_CH-1:0] v,
                      input logic r, input logic [N_CH*W-1:0] d);
    @(posedge clk);
    #1;
    mode = m; sel = s; in_valid = v; out_ready = r; in_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  int exp_ch;
  logic [SW+W-1:0] bp_word;

  initial begin
    rst_n = 1'b0; mode = MODE_RR; sel = '0; in_valid = 4'hF;
    in_data = make_data(0); out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    in_valid = '0;
    rst_n = 1'b1;

    // Fixed mode, sel=2, channel 2 valid.
    step(MODE_FIXED, 2'd2, 4'b0100, 1'b1, {8'h3C, 8'hA5, 8'hC3, 8'h5A});
    exp_q.push_back({2'd2, 8'hA5});
    @(negedge clk);
    check("fix_in_ready", 64'(in_ready), 64'(4'b0100));
    check("fix_pre_valid", 64'(out_valid), 64'(0));
    // Fixed mode, sel=1 but only channel 2 valid: no grant.
    step(MODE_FIXED, 2'd1, 4'b0100, 1'b1, {8'h3C, 8'hA5, 8'hC3, 8'h5A});
    @(negedge clk);
    check("fix_out_valid", 64'(out_valid), 64'(1));
    check("fix_out_ch", 64'(out_ch), 64'(2));
    check("fix_out_data", 64'(out_data), 64'(8'hA5));
    check("nosel_in_ready", 64'(in_ready), 64'(0));
    step(MODE_FIXED, 2'd1, 4'b0100, 1'b1, {8'h3C, 8'hA5, 8'hC3, 8'h5A});
    @(negedge clk);
    check("nosel_out_valid", 64'(out_valid), 64'(0));
    check("nosel_in_ready2", 64'(in_ready), 64'(0));

    // Round-robin, all valid: 0,1,2,3,0,1,2,3 (fixed build: sel=3 each time).
    for (int k = 0; k < 8; k++) begin
      step(MODE_RR, 2'd3, 4'hF, 1'b1, make_data(k));
`ifdef MUX_RR_EN
      exp_ch = k % N_CH;
`else
      exp_ch = 3;
`endif
      exp_q.push_back(exp_word(k, exp_ch));
    end

    // Single channel valid: channel 1 granted every cycle.
    for (int j = 0; j < 3; j++) begin
      step(MODE_RR, 2'd1, 4'b0010, 1'b1, make_data(8 + j));
      exp_q.push_back(exp_word(8 + j, 1));
    end

    // Backpressure: load one word, stall 3 cycles, resume.
`ifdef MUX_RR_EN
    exp_ch = 2;
`else
    exp_ch = 3;
`endif
    bp_word = exp_word(11, exp_ch);
    step(MODE_RR, 2'd3, 4'hF, 1'b1, make_data(11));
    exp_q.push_back(bp_word);
    for (int j = 0; j < 3; j++) begin
      step(MODE_RR, 2'd3, 4'hF, 1'b0, make_data(12 + j));
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_ch", 64'(out_ch), 64'(bp_word[SW+W-1:W]));
      check("bp_out_data", 64'(out_data), 64'(bp_word[W-1:0]));
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    step(MODE_RR, 2'd3, 4'hF, 1'b1, make_data(15));
    exp_q.push_back(exp_word(15, 3));
    step(MODE_RR, 2'd3, 4'h0, 1'b1, make_data(16));

    // Reset mid-stream: load a word under stall, then reset asynchronously.
    step(MODE_RR, 2'd1, 4'hF, 1'b0, make_data(16));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(MODE_RR, 2'd0, 4'hF, 1'b1, make_data(17));
    exp_q.push_back(exp_word(17, 0));
    step(MODE_RR, 2'd0, 4'h0, 1'b1, make_data(18));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("end_out_valid", 64'(out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_nto1_reg.md
# mux_nto1_reg

Parametrised N-channel to 1 multiplexer with per-channel valid/ready handshake and a registered output stage. It is the successor of the team's combinational 2:1 mux: generalised in channel count and data width, with a fixed-select mode and a fair round-robin mode. It sits between several producer streams and one consumer, e.g. merging sensor or UART byte streams onto a shared bus.

## Interface
- N_CH, 4, number of input channels (2..16)
- W, 8, data width per channel (1..64)
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = fixed select via `sel`; 1 = round-robin
- sel  in  SW  channel index used when mode=0
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready, one-hot or zero
- out_data  out  W  registered output data
- out_ch  out  SW  index of the channel that supplied out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts data

## Operation
- Output register: loads when `load = (!out_valid || out_ready) && grant_valid`.
- in_ready[i] = (grant == i) && grant_valid && (!out_valid || out_ready); at most one bit is high.
- Transfer on channel i when in_valid[i] && in_ready[i]; data, index and valid are captured on the same edge.
- out_valid clears when out_ready=1 and no new load occurs; it holds while out_ready=0 (data, out_ch stable).
- Fixed mode (mode=0): grant = sel; grant_valid = in_valid[sel]; sel >= N_CH gives grant_valid=0.
- Round-robin mode (mode=1): pointer `last` (SW bits) holds the last granted channel; search order is last+1, last+2, …, wrapping modulo N_CH, ending at last; first valid channel wins.
- `last` updates only on an accepted transfer in round-robin mode; a stalled output does not advance it.
- Mode or sel changes take effect on the next combinational grant; the output register is unaffected.
- in_valid dropping without a transfer is legal; no state change.

## Timing
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, last=N_CH-1 (so channel 0 wins first); in_ready=0 during reset.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 transfer/cycle while out_ready=1.
- Reset asserted mid-stream: registered word is discarded; no transfer completes on that edge.
- All channels valid, out_ready=1 in RR mode: grants cycle 0,1,2,…,N_CH-1,0.
- Single channel valid: granted every cycle regardless of `last`.
- out_ready=0 with out_valid=1: in_ready all 0.

## Configuration
- MUX_RR_EN defined: round-robin logic and `last` register compiled in; `mode` selects behaviour.
- MUX_RR_EN undefined: `mode` ignored and forced to fixed select; `last` absent; the port list is unchanged.

## Structure
- Package mux_pkg: mode constants MODE_FIXED=1'b0, MODE_RR=1'b1; max channel count constant; reset value of `last`.
- Sub-module rr_arbiter (N_CH param): inputs req, last; outputs grant index and grant_valid; combinational, instantiated only under MUX_RR_EN.

## Test plan
- Reset: hold rst_n=0 with in_valid=4'hF -> out_valid=0, out_data=0, in_ready=0; release -> first RR grant is channel 0.
- Fixed mode, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- Fixed mode, sel=1, in_valid=4'b0100 -> in_ready=0, out_valid stays 0.
- RR mode, in_valid=4'hF, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
- Backpressure: RR mode, out_ready=0 for 3 cycles after first load -> out_data/out_ch stable, in_ready=0, `last` frozen; resume -> next grant is last+1.
- Reset mid-stream: pulse rst_n low while out_valid=1 -> out_valid=0 immediately (asynchronously), RR restarts at channel 0.
